addr8s_sat_acc_seq: RTL and testbench



---
 rtl/addr8s_sat_acc_seq.sv | 154 +++++++++++++++
 tb/tb_addr8s_sat_acc_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addr8s_sat_acc_seq.sv
// Sequential saturating accumulator front-end for the 8-bit signed adder core.
// Each addition is issued twice with swapped operands; results are compared
// and the addition is retried up to MAX_RETRY times before flagging an error.
module addr8s_sat_acc_seq #(
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [8:0] add_sum,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] out_count,
  output logic       out_sat,
  output logic       out_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 9;
  localparam int unsigned RW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {IDLE, ADD1, ADD2, CHECK, OUT} state_t;

  state_t         state, state_nxt;
  logic [DW-1:0]  x;
  logic           last;
  logic [RW-1:0]  retry;
  logic [SW-1:0]  s1, s2;
  logic [DW-1:0]  acc;
  logic [CW-1:0]  count;
  logic           sat_flag;
  logic           err_flag;

  logic           match_c;
  logic           retry_ok_c;
  logic           ovf_c;
  logic [DW-1:0]  sat_c;
  logic [CW-1:0]  count_inc_c;

  // Redundancy compare, retry budget and saturation of the first result
  always_comb begin
    match_c     = (s1 == s2);
    retry_ok_c  = (retry < RW'(MAX_RETRY));
    ovf_c       = s1[8] ^ s1[7];
    sat_c       = s1[DW-1:0];
    if (ovf_c) sat_c = s1[8] ? 8'h80 : 8'h7F;
    count_inc_c = (count == 8'hFF) ? count : CW'(count + 8'd1);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ADD1;
      ADD1:    state_nxt = ADD2;
      ADD2:    state_nxt = CHECK;
      CHECK: begin
        if (!match_c && retry_ok_c) state_nxt = ADD1;
        else if (last)              state_nxt = OUT;
        else                        state_nxt = IDLE;
      end
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; operands are quiet outside the two add phases
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    case (state)
      IDLE:    in_ready = 1'b1;
      ADD1: begin
        add_a = acc;
        add_b = x;
      end
      ADD2: begin
        add_a = x;
        add_b = acc;
      end
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: sample capture, result capture, accumulate and frame flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      last     <= 1'b0;
      retry    <= '0;
      s1       <= '0;
      s2       <= '0;
      acc      <= '0;
      count    <= '0;
      sat_flag <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= in_data;
            last  <= in_last;
            retry <= '0;
          end
        end
        ADD1: s1 <= add_sum;
        ADD2: s2 <= add_sum;
        CHECK: begin
          if (match_c) begin
            acc      <= sat_c;
            sat_flag <= sat_flag | ovf_c;
            count    <= count_inc_c;
          end else if (retry_ok_c) begin
            retry <= RW'(retry + 3'd1);
          end else begin
            err_flag <= 1'b1;
            count    <= count_inc_c;
          end
        end
        OUT: begin
          if (out_ready) begin
            acc      <= '0;
            count    <= '0;
            sat_flag <= 1'b0;
            err_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = acc;
  assign out_count = count;
  assign out_sat   = sat_flag;
  assign out_err   = err_flag;

endmodule

// File: tb/tb_addr8s_sat_acc_seq.sv
// Bench for addr8s_sat_acc_seq: behavioural adder core with fault injection,
// frame vector table, scoreboard of expected frame results, corner sequences.
module tb_addr8s_sat_acc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [8:0] add_sum;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_count;
  logic       out_sat;
  logic       out_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // fault_mode: 0 none, 1 one-shot bit0 flip on first A=x, 2 bit3 wrong on every A=x
  int         fault_mode = 0;
  logic       fault_clear = 1'b0;
  logic       fault_used = 1'b0;
  logic [7:0] cur_x = 8'h00;
  logic [8:0] core_sum;
  logic       ax_phase;

  typedef struct {
    int              n;
    logic [3:0][7:0] s;
    int              mode;
    logic [7:0]      d;
    logic [7:0]      c;
    logic            sat;
    logic            err;
    int              lat;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [7:0] c;
    logic       sat;
    logic       err;
    int         lat;
    int         t0;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  addr8s_sat_acc_seq #(.MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_sat(out_sat), .out_err(out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Adder core model with injected faults on the A=x (swapped) phase
  always_comb begin
    core_sum = {add_a[7], add_a} + {add_b[7], add_b};
    ax_phase = (add_a == cur_x) && (add_b != cur_x);
    add_sum  = core_sum;
    if (fault_mode == 1 && !fault_used && ax_phase) add_sum = core_sum ^ 9'h001;
    if (fault_mode == 2 && ax_phase)                add_sum = core_sum ^ 9'h008;
  end

  always @(posedge clk) begin
    if (fault_clear)                        fault_used <= 1'b0;
    else if (fault_mode == 1 && ax_phase)   fault_used <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_sample(input logic [7:0] d, input logic l, output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    cur_x    = d;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1 t = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect();
    exp_t e;
    int   k;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    k = 0;
    while (!out_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    if (e.lat != 0) chk("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
    chk("out_data",  32'(out_data),  32'(e.d));
    chk("out_count", 32'(out_count), 32'(e.c));
    chk("out_sat",   32'(out_sat),   32'(e.sat));
    chk("out_err",   32'(out_err),   32'(e.err));
    chk("in_ready_in_out", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_xfer", 32'(out_valid), 32'd0);
    chk("in_ready_after_xfer",  32'(in_ready),  32'd1);
    chk("acc_cleared",          32'(out_data),  32'd0);
    chk("count_cleared",        32'(out_count), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int   t;
    exp_t e;
    fault_mode  = v.mode;
    fault_clear = 1'b1;
    @(posedge clk);
    #1 fault_clear = 1'b0;
    e.t0 = 0;
    for (int i = 0; i < v.n; i++) begin
      drive_sample(v.s[i], (i == v.n - 1), t);
      if (i == 0) e.t0 = t;
    end
    e.d = v.d; e.c = v.c; e.sat = v.sat; e.err = v.err; e.lat = v.lat;
    sb.push_back(e);
    collect();
    fault_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    exp_t e;

    //         n   samples {s3,s2,s1,s0}                        mode data   cnt  sat  err  lat
    vecs[0] = '{3, {8'h00, 8'hFB, 8'd20,  8'd10},  0, 8'd25,  8'd3, 1'b0, 1'b0, 12};
    vecs[1] = '{2, {8'h00, 8'h00, 8'd100, 8'd100}, 0, 8'h7F,  8'd2, 1'b1, 1'b0, 8};
    vecs[2] = '{2, {8'h00, 8'h00, 8'h9C,  8'h9C},  0, 8'h80,  8'd2, 1'b1, 1'b0, 8};
    vecs[3] = '{1, {8'h00, 8'h00, 8'h00,  8'd5},   1, 8'd5,   8'd1, 1'b0, 1'b0, 7};
    vecs[4] = '{2, {8'h00, 8'h00, 8'd1,   8'd8},   2, 8'd0,   8'd2, 1'b0, 1'b1, 20};
    vecs[5] = '{3, {8'h00, 8'hFF, 8'd1,   8'd127}, 0, 8'd126, 8'd3, 1'b1, 1'b0, 12};
    vecs[6] = '{3, {8'h00, 8'd127, 8'h80, 8'h80},  0, 8'hFF,  8'd3, 1'b1, 1'b0, 12};
    vecs[7] = '{1, {8'h00, 8'h00, 8'h00,  8'd1},   0, 8'd1,   8'd1, 1'b0, 1'b0, 4};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_flags",     32'({out_sat, out_err}), 32'd0);
    chk("rst_operands",  32'({add_a, add_b}),     32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-pressure: result held while out_ready low, in_valid ignored
    drive_sample(8'd1, 1'b0, t);
    e.t0 = t;
    drive_sample(8'd2, 1'b1, t);
    e.d = 8'd3; e.c = 8'd2; e.sat = 1'b0; e.err = 1'b0; e.lat = 0;
    sb.push_back(e);
    begin
      int k;
      k = 0;
      while (!out_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data",  32'(out_data),  32'd3);
      chk("bp_out_count", 32'(out_count), 32'd2);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      in_data  = 8'h55;
      in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect();
    run_vec('{1, {8'h00, 8'h00, 8'h00, 8'd7}, 0, 8'd7, 8'd1, 1'b0, 1'b0, 4});

    // Sample counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      drive_sample(8'd0, (i == 299), t);
      if (i == 0) e.t0 = t;
    end
    e.d = 8'd0; e.c = 8'd255; e.sat = 1'b0; e.err = 1'b0; e.lat = 1200;
    sb.push_back(e);
    collect();

    // Operand swap, then asynchronous reset during ADD2 of the second sample
    drive_sample(8'd20, 1'b0, t);
    drive_sample(8'd50, 1'b0, t);
    chk("add1_a", 32'(add_a), 32'd20);
    chk("add1_b", 32'(add_b), 32'd50);
    chk("pre_rst_acc", 32'(out_data), 32'd20);
    @(negedge clk);
    chk("add2_a", 32'(add_a), 32'd50);
    chk("add2_b", 32'(add_b), 32'd20);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_operands",  32'({add_a, add_b}), 32'd0);
    chk("arst_out_data",  32'(out_data),  32'd0);
    chk("arst_out_count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec('{1, {8'h00, 8'h00, 8'h00, 8'd3}, 0, 8'd3, 8'd1, 1'b0, 1'b0, 4});

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
